// File: rtl/dm_load_unit.sv
// dm_load_unit: single-outstanding data-memory load unit.
// Accepts one load at a time, issues a one-cycle word-aligned read,
// waits for the memory (bounded by TIMEOUT_CYCLES), then extracts and
// sign/zero-extends the requested lanes. The result is held until the
// consumer takes it. Address misalignment and illegal load types are
// answered directly without touching memory.
module dm_load_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_pc,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   output logic [3:0]  byte_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [31:0] rsp_pc,
   output logic [1:0]  rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [2:0] T_LW  = 3'b000;
   localparam logic [2:0] T_LH  = 3'b001;
   localparam logic [2:0] T_LHU = 3'b010;
   localparam logic [2:0] T_LB  = 3'b011;
   localparam logic [2:0] T_LBU = 3'b100;

   localparam logic [1:0] E_OK       = 2'b00;
   localparam logic [1:0] E_MISALIGN = 2'b01;
   localparam logic [1:0] E_TIMEOUT  = 2'b10;
   localparam logic [1:0] E_ILLEGAL  = 2'b11;

   // Counter width covers the full 1..255 range of the timeout.
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [2:0]  type_q;
   logic [1:0]  offset_q;

   logic        accept;
   logic        timeout_hit;
   logic [1:0]  req_err;
   logic [3:0]  lane_mask;
   logic [31:0] load_result;

   // Picks the addressed lane(s) out of the memory word and extends them.
   function automatic logic [31:0] extract(input logic [2:0]  ltype,
                                           input logic [1:0]  offset,
                                           input logic [31:0] word);
      logic [15:0] half;
      logic [7:0]  byte_v;
      half   = offset[1] ? word[31:16] : word[15:0];
      byte_v = word[8*offset +: 8];
      case (ltype)
         T_LW:    extract = word;
         T_LH:    extract = {{16{half[15]}}, half};
         T_LHU:   extract = {16'h0000, half};
         T_LB:    extract = {{24{byte_v[7]}}, byte_v};
         T_LBU:   extract = {24'h000000, byte_v};
         default: extract = 32'h0000_0000;
      endcase
   endfunction

   assign accept      = (state == S_IDLE) && req_valid;
   assign timeout_hit = (wait_cnt == TIMEOUT_LIMIT);
   assign load_result = extract(type_q, offset_q, mem_rdata);

   // Classify the incoming request: illegal type takes priority over misalignment.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
      req_err = E_OK;
      if (req_type > T_LBU)
         req_err = E_ILLEGAL;
      else if ((req_type == T_LW) && (req_addr[1:0] != 2'b00))
         req_err = E_MISALIGN;
      else if (((req_type == T_LH) || (req_type == T_LHU)) && req_addr[0])
         req_err = E_MISALIGN;
   end

   // Byte-lane mask for the incoming request.
   always_comb begin
      lane_mask = 4'b0000;
      case (req_type)
         T_LW:        lane_mask = 4'b1111;
         T_LH, T_LHU: lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
         T_LB, T_LBU: lane_mask = 4'b0001 << req_addr[1:0];
         default:     lane_mask = 4'b0000;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
      if (!reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (req_valid) state_next = (req_err == E_OK) ? S_ISSUE : S_RESP;
         S_ISSUE: state_next = S_WAIT;
         S_WAIT:  if (mem_rvalid || timeout_hit) state_next = S_RESP;
         S_RESP:  if (rsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake and strobe outputs decoded from the state.
   always_comb begin
      req_ready = (state == S_IDLE);
      mem_rd_en = (state == S_ISSUE);
      rsp_valid = (state == S_RESP);
   end

   // WAIT cycle counter: 1 on the first WAIT cycle, cleared outside WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt <= 8'd0;
      else if (state == S_ISSUE)
         wait_cnt <= 8'd1;
      else if (state == S_WAIT)
         wait_cnt <= wait_cnt + 8'd1;
      else
         wait_cnt <= 8'd0;
   end

   // Request latch and response capture.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: datapath registers are reset too, because their values are visible on ports during and right after reset.
      if (!reset) begin
         mem_addr <= 32'h0000_0000;
         byte_en  <= 4'b0000;
         type_q   <= 3'b000;
         offset_q <= 2'b00;
         rsp_pc   <= 32'h0000_0000;
         rsp_data <= 32'h0000_0000;
         rsp_err  <= E_OK;
      end else if (accept) begin
         mem_addr <= {req_addr[31:2], 2'b00};
         byte_en  <= lane_mask;
         type_q   <= req_type;
         offset_q <= req_addr[1:0];
         rsp_pc   <= req_pc;
         rsp_data <= 32'h0000_0000;
         rsp_err  <= req_err;
      end else if (state == S_WAIT) begin
         // A returning read wins over a timeout in the same cycle.
         if (mem_rvalid) begin
            rsp_data <= load_result;
            rsp_err  <= E_OK;
         end else if (timeout_hit) begin
            rsp_data <= 32'h0000_0000;
            rsp_err  <= E_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_dm_load_unit.sv
// Scoreboard bench for dm_load_unit (TIMEOUT_CYCLES = 4).
// Expected responses are queued when a load is driven and compared when
// the unit hands the response over.
module tb_dm_load_unit;

   localparam int TMO = 4;

   localparam logic [2:0] LW  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LHU = 3'b010;
   localparam logic [2:0] LB  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic [1:0]  err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_type = '0;
   logic [31:0] req_pc = '0;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [3:0]  byte_en;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [31:0] rsp_pc;
   logic [1:0]  rsp_err;

   int   n_checks = 0;
   int   n_errors = 0;
   rsp_t sb[$];

   dm_load_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_type   (req_type),
      .req_pc     (req_pc),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .byte_en    (byte_en),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_pc     (rsp_pc),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference model.
   function automatic logic [1:0] m_err(input logic [2:0] t, input logic [31:0] a);
      if (t >= 3'd5) return 2'b11;
      if (t == LW && a[1:0] != 2'b00) return 2'b01;
      if ((t == LH || t == LHU) && a[0]) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
      case (t)
         LW:      return 4'b1111;
         LH, LHU: return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
         default: case (a[1:0])
                     2'd0:    return 4'b0001;
                     2'd1:    return 4'b0010;
                     2'd2:    return 4'b0100;
                     default: return 4'b1000;
                  endcase
      endcase
   endfunction

   function automatic logic [31:0] m_data(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (a[1:0] * 8);
      if (t == LH || t == LHU) sh = a[1] ? (w >> 16) : w;
      case (t)
         LW:      return w;
         LH:      return sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
         LHU:     return sh & 32'h0000_FFFF;
         LB:      return sh[7] ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
         default: return sh & 32'h0000_00FF;
      endcase
   endfunction

   // Drive one load end-to-end. delay: WAIT cycles before rvalid (-1 = never).
   // hold: extra cycles rsp_ready stays low. poke: pulse req_valid while held.
   task automatic run_load(input string name, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] pc, input logic [31:0] w,
                           input int delay, input int hold, input bit poke);
      rsp_t exp;
      int   cyc;
      int   exp_lat;
      exp.err  = m_err(t, a);
      exp.pc   = pc;
      exp.data = 32'h0;
      if (exp.err == 2'b00) begin
         if (delay < 0 || delay >= TMO) exp.err = 2'b10;
         else exp.data = m_data(t, a, w);
      end
      sb.push_back(exp);
      if (m_err(t, a) != 2'b00) exp_lat = 1;
      else if (delay < 0 || delay >= TMO) exp_lat = 2 + TMO;
      else exp_lat = 3 + delay;

      @(negedge clk);
      check({name, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_type = t; req_addr = a; req_pc = pc;
      mem_rdata = w;
      @(negedge clk);
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_pc = 32'h0;
      cyc = 1;
      if (m_err(t, a) == 2'b00) begin
         check({name, ".rd_en"}, 32'(mem_rd_en), 32'd1);
         check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
         check({name, ".byte_en"}, 32'(byte_en), 32'(m_be(t, a)));
         @(negedge clk);
         cyc++;
         check({name, ".rd_en_wait"}, 32'(mem_rd_en), 32'd0);
         check({name, ".mem_addr_hold"}, mem_addr, {a[31:2], 2'b00});
         if (delay >= 0 && delay < TMO) begin
            repeat (delay) begin
               @(negedge clk);
               cyc++;
            end
            mem_rvalid = 1'b1;
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
         end
      end else begin
         check({name, ".no_rd_en"}, 32'(mem_rd_en), 32'd0);
      end
      while (!rsp_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         check({name, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         check({name, ".hold_data"}, rsp_data, sb[0].data);
         check({name, ".hold_pc"}, rsp_pc, sb[0].pc);
         check({name, ".hold_ready"}, 32'(req_ready), 32'd0);
         req_valid = (poke && i == 1);
         req_type = LB; req_addr = 32'h40; req_pc = 32'hDEAD_0000;
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      exp = sb.pop_front();
      check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, ".rsp_data"}, rsp_data, exp.data);
      check({name, ".rsp_pc"}, rsp_pc, exp.pc);
      check({name, ".rsp_err"}, 32'(rsp_err), 32'(exp.err));
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, ".idle_valid"}, 32'(rsp_valid), 32'd0);
      check({name, ".idle_ready"}, 32'(req_ready), 32'd1);
      if (poke) begin
         @(negedge clk);
         check({name, ".no_stray_issue"}, 32'(mem_rd_en), 32'd0);
      end
   endtask

   task automatic check_reset_values(input string name);
      check({name, ".req_ready"}, 32'(req_ready), 32'd1);
      check({name, ".mem_rd_en"}, 32'(mem_rd_en), 32'd0);
      check({name, ".mem_addr"}, mem_addr, 32'd0);
      check({name, ".byte_en"}, 32'(byte_en), 32'd0);
      check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({name, ".rsp_data"}, rsp_data, 32'd0);
      check({name, ".rsp_pc"}, rsp_pc, 32'd0);
      check({name, ".rsp_err"}, 32'(rsp_err), 32'd0);
   endtask

   initial begin
      #2;
      check_reset_values("por");
      @(negedge clk);
      reset = 1'b1;

      run_load("lb_neg",     LB,  32'h0000_0003, 32'h0000_1000, 32'h80AB_CDEF, 0, 0, 1'b0);
      run_load("lhu_hi",     LHU, 32'h0000_0012, 32'h0000_1004, 32'h8001_7FFF, 0, 0, 1'b0);
      run_load("lh_hi",      LH,  32'h0000_0012, 32'h0000_1008, 32'h8001_7FFF, 1, 0, 1'b0);
      run_load("lh_lo",      LH,  32'h0000_0010, 32'h0000_100C, 32'h1234_F00D, 2, 0, 1'b0);
      run_load("lbu_b1",     LBU, 32'h0000_0041, 32'h0000_1010, 32'h1122_B344, 0, 0, 1'b0);
      run_load("lb_pos",     LB,  32'h0000_0046, 32'h0000_1014, 32'hAA7F_CCDD, 0, 0, 1'b0);
      run_load("lw",         LW,  32'h0000_0100, 32'h0000_1018, 32'hCAFE_BABE, 1, 0, 1'b0);
      run_load("lw_mis",     LW,  32'h0000_0006, 32'h0000_101C, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_load("lhu_mis",    LHU, 32'h0000_0013, 32'h0000_1020, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_load("illegal",    3'b110, 32'h0000_0000, 32'h0000_1024, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_load("illegal_mis",3'b111, 32'h0000_0003, 32'h0000_1028, 32'hFFFF_FFFF, 0, 0, 1'b0);
      run_load("timeout",    LW,  32'h0000_0020, 32'h0000_102C, 32'h5555_AAAA, -1, 0, 1'b0);
      run_load("rv_last",    LW,  32'h0000_0020, 32'h0000_1030, 32'h5555_AAAA, TMO - 1, 0, 1'b0);
      run_load("backpress",  LH,  32'h0000_0002, 32'h0000_1034, 32'h9ABC_0001, 0, 5, 1'b1);

      // Reset in the middle of WAIT, then a late rvalid.
      @(negedge clk);
      req_valid = 1'b1; req_type = LW; req_addr = 32'h0000_0020; req_pc = 32'h0000_2000;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_reset_values("mid_rst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_rv.rsp_valid", 32'(rsp_valid), 32'd0);
         check("late_rv.req_ready", 32'(req_ready), 32'd1);
         @(negedge clk);
      end

      run_load("after_rst",  LBU, 32'h0000_0082, 32'h0000_1038, 32'h00FE_0000, 0, 0, 1'b0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dm_load_unit.md
DM_LOAD_UNIT -- requirements
Module: dm_load_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent in WAIT before a timeout response (range 1..255).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid  in  1  load request present.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port req_addr  in  32  byte address of the load.
REQ-007 SHALL have port req_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101-111 illegal.
REQ-008 SHALL have port req_pc  in  32  PC of the load instruction, carried to the response.
REQ-009 SHALL have port mem_rd_en  out  1  one-cycle read strobe to the data memory.
REQ-010 SHALL have port mem_addr  out  32  word-aligned read address {addr[31:2],2'b00}.
REQ-011 SHALL have port byte_en  out  4  lanes being read, same encoding as the write-side Bit_Type: 1111, 0011/1100, 0001/0010/0100/1000.
REQ-012 SHALL have port mem_rdata  in  32  read word from memory.
REQ-013 SHALL have port mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-014 SHALL have port rsp_valid  out  1  response present.
REQ-015 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-016 SHALL have port rsp_data  out  32  extended load result.
REQ-017 SHALL have port rsp_pc  out  32  latched req_pc.
REQ-018 SHALL have port rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal type.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-020 In IDLE, on req_valid, SHALL latch addr, type, pc; next state ISSUE if legal and aligned, else RESP with rsp_err 11 (illegal type, checked first) or 01.
REQ-021 Misaligned SHALL mean LW with addr[1:0] != 0, or LH/LHU with addr[0] != 0; byte loads are never misaligned.
REQ-022 In ISSUE, mem_rd_en SHALL be 1 for exactly one cycle, with mem_addr and byte_en valid; next state WAIT unconditionally.
REQ-023 mem_rd_en SHALL be 0 in every other state; mem_addr and byte_en SHALL hold their latched values until the next accept.
REQ-024 mem_rvalid SHALL be sampled only in WAIT and ignored in all other states.
REQ-025 In WAIT, on mem_rvalid, SHALL capture the extracted data and go to RESP with rsp_err 00.
REQ-026 WAIT SHALL count cycles from 1; if the count reaches TIMEOUT_CYCLES without mem_rvalid, SHALL go to RESP with rsp_err 10 and rsp_data 0.
REQ-027 If mem_rvalid and timeout coincide in the same cycle, mem_rvalid SHALL win (rsp_err 00).
REQ-028 Extraction: LW SHALL return the full word.
REQ-029 Extraction: LH/LHU SHALL select [15:0] if addr[1] = 0, else [31:16].
REQ-030 Extraction: LB/LBU SHALL select byte addr[1:0], i.e. bits [8k+7:8k].
REQ-031 LH/LB SHALL sign-extend to 32 bits; LHU/LBU SHALL zero-extend.
REQ-032 On any error response, rsp_data SHALL be 0.
REQ-033 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_pc and rsp_err SHALL be stable until rsp_ready = 1; on rsp_ready the unit SHALL return to IDLE the next cycle.
REQ-034 A new request SHALL NOT be accepted in the cycle rsp_ready is taken; one IDLE cycle minimum.
REQ-035 Best-case latency from accept edge to rsp_valid SHALL be 3 cycles (ISSUE, WAIT with mem_rvalid, RESP).

Reset
REQ-036 While reset = 0, regardless of clk, SHALL force state IDLE, wait count 0, and outputs req_ready 1, mem_rd_en 0, mem_addr 0, byte_en 0, rsp_valid 0, rsp_data 0, rsp_pc 0, rsp_err 00.
REQ-037 Reset asserted mid-transaction (ISSUE, WAIT or RESP) SHALL abandon the transaction with no response; a late mem_rvalid after release SHALL be ignored.

Verification
REQ-038 LB, addr 0x0000_0003, mem_rdata 0x80AB_CDEF, rvalid 1 cycle after strobe -> mem_addr 0x0000_0000, byte_en 1000, rsp_data 0xFFFF_FF80, rsp_err 00.
REQ-039 LHU, addr 0x0000_0012, mem_rdata 0x8001_7FFF -> mem_addr 0x0000_0010, byte_en 1100, rsp_data 0x0000_8001; with LH the same request -> 0xFFFF_8001.
REQ-040 LW, addr 0x0000_0006 -> no mem_rd_en pulse, rsp_err 01, rsp_data 0; req_type 110 -> rsp_err 11.
REQ-041 TIMEOUT_CYCLES 4, LW, addr 0x0000_0020, mem_rvalid never asserted -> rsp_err 10 after 4 WAIT cycles; rvalid on the 4th WAIT cycle -> rsp_err 00.
REQ-042 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_pc stable throughout, req_ready 0, and a req_valid pulse during this time is not accepted.
REQ-043 reset driven low during WAIT -> outputs reach reset values immediately (before the next clk edge); a mem_rvalid after release produces no rsp_valid.
